// File: rtl/sd_cmd_responder_if.sv
// CMD-line and response-request signals of the SD command responder.
// The slave modport is the responder; the master modport is whoever drives it.
interface sd_cmd_responder_if;
  logic        istrobe;
  logic        icmd;
  logic        ocmd;
  logic        ocmd_oe;
  logic [5:0]  oindex;
  logic [31:0] oarg;
  logic        ovalid;
  logic        oerr;
  logic        ordy;
  logic        irsp_valid;
  logic        irsp_skip;
  logic [5:0]  irsp_index;
  logic [31:0] irsp_arg;

  modport slave (
    input  istrobe, icmd, irsp_valid, irsp_skip, irsp_index, irsp_arg,
    output ocmd, ocmd_oe, oindex, oarg, ovalid, oerr, ordy
  );

  modport master (
    output istrobe, icmd, irsp_valid, irsp_skip, irsp_index, irsp_arg,
    input  ocmd, ocmd_oe, oindex, oarg, ovalid, oerr, ordy
  );
endinterface

// File: rtl/sd_cmd_responder.sv
// SD card side CMD-line engine: receives a 48-bit command frame, reports it,
// and after the NCR gap transmits a 48-bit response frame with CRC7.
module sd_cmd_responder #(
  parameter int NCR = 2
) (
  input  logic                 iclk,
  input  logic                 irst,
  sd_cmd_responder_if.slave    cmd_if
);

  typedef enum logic [2:0] {IDLE, RECV, WAIT_RSP, GAP, SEND} state_t;

  localparam logic [6:0] NCR_W = 7'(NCR);

  state_t      state_q;
  logic [5:0]  bit_cnt_q;
  logic [6:0]  gap_q;
  logic [6:0]  crc_q;
  logic [44:0] rx_sh_q;
  logic [47:0] tx_q;
  logic        ocmd_q;
  logic        ocmd_oe_q;
  logic [5:0]  oindex_q;
  logic [31:0] oarg_q;
  logic        ovalid_q;
  logic        oerr_q;
  logic        ordy_q;

  logic [6:0]  crc_d;
  logic [39:0] rsp_head_d;
  logic [47:0] rsp_frame_d;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  endfunction

  function automatic logic [6:0] crc7_40(input logic [39:0] d);
    logic [6:0] c;
    c = 7'd0;
    for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
    return c;
  endfunction

  always_comb begin
    crc_d       = crc7_step(crc_q, cmd_if.icmd);
    rsp_head_d  = {2'b00, cmd_if.irsp_index, cmd_if.irsp_arg};
    rsp_frame_d = {rsp_head_d, crc7_40(rsp_head_d), 1'b1};
  end

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      state_q   <= IDLE;
      bit_cnt_q <= 6'd0;
      gap_q     <= 7'd0;
      crc_q     <= 7'd0;
      rx_sh_q   <= '0;
      tx_q      <= '0;
      ocmd_q    <= 1'b1;
      ocmd_oe_q <= 1'b0;
      oindex_q  <= 6'd0;
      oarg_q    <= 32'd0;
      ovalid_q  <= 1'b0;
      oerr_q    <= 1'b0;
      ordy_q    <= 1'b0;
    end else begin
      ovalid_q <= 1'b0;
      oerr_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          // A zero start bit leaves a zero-initialised CRC7 unchanged.
          if (cmd_if.istrobe && !cmd_if.icmd) begin
            state_q   <= RECV;
            bit_cnt_q <= 6'd1;
            crc_q     <= 7'd0;
          end
        end
        RECV: begin
          if (cmd_if.istrobe) begin
            rx_sh_q   <= {rx_sh_q[43:0], cmd_if.icmd};
            bit_cnt_q <= bit_cnt_q + 6'd1;
            if (bit_cnt_q <= 6'd39) crc_q <= crc_d;
            if (bit_cnt_q == 6'd1 && !cmd_if.icmd) begin
              oerr_q  <= 1'b1;
              state_q <= IDLE;
            end else if (bit_cnt_q == 6'd47) begin
              // rx_sh_q now holds frame bits 3..47: index, argument, CRC.
              if (cmd_if.icmd && crc_q == rx_sh_q[6:0]) begin
                oindex_q <= rx_sh_q[44:39];
                oarg_q   <= rx_sh_q[38:7];
                ovalid_q <= 1'b1;
                ordy_q   <= 1'b1;
                gap_q    <= 7'd0;
                state_q  <= WAIT_RSP;
              end else begin
                oerr_q  <= 1'b1;
                state_q <= IDLE;
              end
            end
          end
        end
        WAIT_RSP: begin
          if (cmd_if.istrobe && gap_q < NCR_W) gap_q <= gap_q + 7'd1;
          if (cmd_if.irsp_skip) begin
            ordy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (cmd_if.irsp_valid) begin
            tx_q    <= rsp_frame_d;
            ordy_q  <= 1'b0;
            state_q <= GAP;
          end
        end
        GAP: begin
          if (cmd_if.istrobe) begin
            if (gap_q >= NCR_W) begin
              ocmd_q    <= tx_q[47];
              tx_q      <= {tx_q[46:0], 1'b0};
              ocmd_oe_q <= 1'b1;
              bit_cnt_q <= 6'd1;
              state_q   <= SEND;
            end else begin
              gap_q <= gap_q + 7'd1;
            end
          end
        end
        SEND: begin
          if (cmd_if.istrobe) begin
            if (bit_cnt_q == 6'd48) begin
              ocmd_q    <= 1'b1;
              ocmd_oe_q <= 1'b0;
              bit_cnt_q <= 6'd0;
              state_q   <= IDLE;
            end else begin
              ocmd_q    <= tx_q[47];
              tx_q      <= {tx_q[46:0], 1'b0};
              bit_cnt_q <= bit_cnt_q + 6'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_if.ocmd    = ocmd_q;
  assign cmd_if.ocmd_oe = ocmd_oe_q;
  assign cmd_if.oindex  = oindex_q;
  assign cmd_if.oarg    = oarg_q;
  assign cmd_if.ovalid  = ovalid_q;
  assign cmd_if.oerr    = oerr_q;
  assign cmd_if.ordy    = ordy_q;

endmodule

// File: tb/tb_sd_cmd_responder.sv
// Directed bench for sd_cmd_responder: table of command frames plus
// hand-written response, delay, reset-abort and stray-request sequences.
module tb_sd_cmd_responder;

  logic iclk;
  logic irst;
  sd_cmd_responder_if bus();

  sd_cmd_responder #(.NCR(2)) dut (
    .iclk   (iclk),
    .irst   (irst),
    .cmd_if (bus.slave)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  int total = 0;
  int bad   = 0;
  int oe_seen = 0;

  always @(negedge iclk) if (bus.ocmd_oe) oe_seen <= oe_seen + 1;

  logic s_oe, s_ocmd, s_valid, s_err, s_rdy;

  typedef struct {
    logic [47:0] frame;
    logic        exp_valid;
    int          exp_eslot;
    logic [5:0]  exp_idx;
    logic [31:0] exp_arg;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One bit slot: strobe for a single clock, then sample the registered outputs.
  task automatic strobe(input logic c);
    @(negedge iclk);
    bus.icmd    = c;
    bus.istrobe = 1'b1;
    @(negedge iclk);
    bus.istrobe = 1'b0;
    s_oe    = bus.ocmd_oe;
    s_ocmd  = bus.ocmd;
    s_valid = bus.ovalid;
    s_err   = bus.oerr;
    s_rdy   = bus.ordy;
    @(negedge iclk);
    bus.icmd = 1'b1;
  endtask

  task automatic send_frame(input logic [47:0] f, output int nv, output int ne, output int eslot);
    nv = 0; ne = 0; eslot = 0;
    for (int i = 47; i >= 0; i--) begin
      strobe(f[i]);
      if (s_valid) nv++;
      if (s_err) begin
        ne++;
        eslot = 48 - i;
        break;
      end
    end
  endtask

  task automatic pulse_skip();
    @(negedge iclk);
    bus.irsp_skip = 1'b1;
    @(negedge iclk);
    bus.irsp_skip = 1'b0;
  endtask

  task automatic pulse_rsp(input logic [5:0] idx, input logic [31:0] arg);
    @(negedge iclk);
    bus.irsp_index = idx;
    bus.irsp_arg   = arg;
    bus.irsp_valid = 1'b1;
    @(negedge iclk);
    bus.irsp_valid = 1'b0;
  endtask

  // Strobe until the response ends; bounded so a stuck DUT cannot hang the run.
  task automatic capture_rsp(output logic [47:0] bits, output int idle, output int oe_n,
                             output logic done, output logic end_cmd);
    bits = '0; idle = 0; oe_n = 0; done = 1'b0; end_cmd = 1'b0;
    for (int k = 0; k < 120; k++) begin
      strobe(1'b1);
      if (s_oe) begin
        bits = {bits[46:0], s_ocmd};
        oe_n++;
      end else if (oe_n > 0) begin
        done = 1'b1;
        end_cmd = s_ocmd;
        break;
      end else begin
        idle++;
      end
    end
  endtask

  int nv, ne, es, idle, oe_n, oe_base;
  logic [47:0] rbits;
  logic done, end_cmd;
  logic [5:0]  m_idx;
  logic [31:0] m_arg;

  initial begin
    vecs[0] = '{48'h400000000095, 1'b1, 0,  6'd0,  32'h0};
    vecs[1] = '{48'h48000001AA87, 1'b1, 0,  6'd8,  32'h1AA};
    vecs[2] = '{48'h510000000057, 1'b0, 48, 6'd0,  32'h0};
    vecs[3] = '{48'h510000000055, 1'b1, 0,  6'd17, 32'h0};
    vecs[4] = '{48'h000000000095, 1'b0, 2,  6'd0,  32'h0};
    vecs[5] = '{48'h400000000094, 1'b0, 48, 6'd0,  32'h0};
    vecs[6] = '{48'h770000000065, 1'b1, 0,  6'd55, 32'h0};

    irst = 1'b0;
    bus.istrobe = 1'b0; bus.icmd = 1'b1;
    bus.irsp_valid = 1'b0; bus.irsp_skip = 1'b0;
    bus.irsp_index = 6'd0; bus.irsp_arg = 32'd0;
    repeat (3) @(negedge iclk);
    check("reset_ocmd", 64'(bus.ocmd), 64'd1);
    check("reset_oe", 64'(bus.ocmd_oe), 64'd0);
    check("reset_flags", {61'd0, bus.ovalid, bus.oerr, bus.ordy}, 64'd0);
    check("reset_fields", {26'd0, bus.oindex, bus.oarg}, 64'd0);
    irst = 1'b1;
    strobe(1'b1);

    m_idx = 6'd0; m_arg = 32'd0;
    for (int v = 0; v < 7; v++) begin
      oe_base = oe_seen;
      send_frame(vecs[v].frame, nv, ne, es);
      check($sformatf("v%0d_valid", v), 64'(nv), 64'(vecs[v].exp_valid));
      check($sformatf("v%0d_err", v), 64'(ne), vecs[v].exp_valid ? 64'd0 : 64'd1);
      check($sformatf("v%0d_errslot", v), 64'(es), 64'(vecs[v].exp_eslot));
      check($sformatf("v%0d_rdy", v), 64'(s_rdy), 64'(vecs[v].exp_valid));
      if (vecs[v].exp_valid) begin
        m_idx = vecs[v].exp_idx;
        m_arg = vecs[v].exp_arg;
      end
      check($sformatf("v%0d_fields", v), {26'd0, bus.oindex, bus.oarg}, {26'd0, m_idx, m_arg});
      if (vecs[v].exp_valid) begin
        pulse_skip();
        check($sformatf("v%0d_rdy_after_skip", v), 64'(bus.ordy), 64'd0);
      end
      strobe(1'b1);
      strobe(1'b1);
      check($sformatf("v%0d_no_oe", v), 64'(oe_seen - oe_base), 64'd0);
    end

    // CMD8 answered immediately: NCR idle slots then the R7 frame.
    send_frame(48'h48000001AA87, nv, ne, es);
    check("cmd8_valid", 64'(nv), 64'd1);
    pulse_rsp(6'd8, 32'h1AA);
    check("cmd8_rdy_low", 64'(bus.ordy), 64'd0);
    capture_rsp(rbits, idle, oe_n, done, end_cmd);
    check("cmd8_idle", 64'(idle), 64'd2);
    check("cmd8_oe_len", 64'(oe_n), 64'd48);
    check("cmd8_bits", 64'(rbits), 64'h08000001AA13);
    check("cmd8_done", {62'd0, done, end_cmd}, 64'd3);

    // Late response: 10 slots already elapsed, so SEND starts on next strobe.
    send_frame(48'h48000001AA87, nv, ne, es);
    for (int k = 0; k < 10; k++) strobe(1'b0);
    check("late_rdy_held", {62'd0, s_rdy, s_oe}, 64'd2);
    pulse_rsp(6'd8, 32'h1AA);
    capture_rsp(rbits, idle, oe_n, done, end_cmd);
    check("late_idle", 64'(idle), 64'd0);
    check("late_bits", 64'(rbits), 64'h08000001AA13);
    check("late_oe_len", 64'(oe_n), 64'd48);

    // Response request while idle must be ignored.
    oe_base = oe_seen;
    pulse_rsp(6'd3, 32'h12345678);
    for (int k = 0; k < 60; k++) strobe(1'b1);
    check("idle_rsp_no_oe", 64'(oe_seen - oe_base), 64'd0);
    check("idle_rsp_rdy", 64'(bus.ordy), 64'd0);

    // Reset in the middle of response bit 20 releases the line at once.
    send_frame(48'h48000001AA87, nv, ne, es);
    pulse_rsp(6'd8, 32'h1AA);
    strobe(1'b1); strobe(1'b1);
    for (int k = 0; k < 20; k++) strobe(1'b1);
    check("midsend_oe", 64'(s_oe), 64'd1);
    #2 irst = 1'b0;
    #1;
    check("rst_async_line", {62'd0, bus.ocmd, bus.ocmd_oe}, 64'd2);
    check("rst_async_flags", {61'd0, bus.ovalid, bus.oerr, bus.ordy}, 64'd0);
    check("rst_async_fields", {26'd0, bus.oindex, bus.oarg}, 64'd0);
    @(negedge iclk);
    irst = 1'b1;
    oe_base = oe_seen;
    for (int k = 0; k < 30; k++) strobe(1'b1);
    check("post_rst_quiet", {62'd0, s_valid, s_err}, 64'd0);
    check("post_rst_no_oe", 64'(oe_seen - oe_base), 64'd0);

    // Reset mid-receive, then a fresh CMD0 is taken cleanly.
    for (int i = 47; i >= 28; i--) strobe(vecs[1].frame[i]);
    @(negedge iclk); irst = 1'b0;
    @(negedge iclk); irst = 1'b1;
    send_frame(48'h400000000095, nv, ne, es);
    check("midrecv_then_cmd0", {32'(nv), 32'(ne)}, {32'd1, 32'd0});
    check("midrecv_cmd0_fields", {26'd0, bus.oindex, bus.oarg}, 64'd0);
    pulse_skip();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sd_cmd_responder.md
SD_CMD_RESPONDER -- requirements
Module: sd_cmd_responder

Interface
REQ-001 The module SHALL have parameter NCR, default 2, giving the number of idle bit slots between command end bit and response start bit (legal range 2..64).
REQ-002 The module SHALL have port iclk, input, 1, system clock (36 MHz); all logic on its rising edge.
REQ-003 The module SHALL have port irst, input, 1, reset, asynchronous and active-low.
REQ-004 The module SHALL have port istrobe, input, 1, one-cycle bit-slot tick (SD clock rising edge); all CMD-line activity advances only on istrobe.
REQ-005 The module SHALL have port icmd, input, 1, synchronized CMD line level.
REQ-006 The module SHALL have port ocmd, output, 1, CMD line drive value.
REQ-007 The module SHALL have port ocmd_oe, output, 1, CMD line output enable.
REQ-008 The module SHALL have ports oindex (6), oarg (32), ovalid (1), outputs: received command fields; ovalid is a one-cycle pulse.
REQ-009 The module SHALL have port oerr, output, 1, one-cycle pulse on a rejected frame.
REQ-010 The module SHALL have port ordy, output, 1, high while a response is awaited.
REQ-011 The module SHALL have ports irsp_valid (1), irsp_skip (1), irsp_index (6), irsp_arg (32), inputs: response request, no-response request, response fields.

Function
REQ-012 The module SHALL implement states IDLE, RECV, WAIT_RSP, GAP, SEND.
REQ-013 In IDLE, on istrobe with icmd=0 (start bit), the module SHALL enter RECV with bit count 1; icmd=1 SHALL keep IDLE.
REQ-014 In RECV, each istrobe SHALL shift icmd in MSB-first until 48 bits are held (start, transmission, index[5:0], arg[31:0], crc[6:0], end).
REQ-015 If the transmission bit (bit 2) is 0, the module SHALL pulse oerr on that slot and return to IDLE.
REQ-016 CRC7 SHALL use polynomial x^7+x^3+1, register init 0, over the first 40 bits, and SHALL be compared with received bits 41..47.
REQ-017 On the end-bit slot, CRC mismatch or end bit 0 SHALL pulse oerr and return to IDLE; otherwise the module SHALL latch oindex/oarg, pulse ovalid, and enter WAIT_RSP, all in the cycle after that istrobe.
REQ-018 oindex/oarg SHALL hold their value until the next ovalid.
REQ-019 ordy SHALL be 1 only in WAIT_RSP.
REQ-020 In WAIT_RSP, irsp_skip=1 SHALL return to IDLE; otherwise irsp_valid=1 SHALL latch irsp_index/irsp_arg and enter GAP; skip has priority if both are high; both inputs SHALL be ignored outside WAIT_RSP.
REQ-021 GAP SHALL last until NCR istrobe slots have elapsed counted from the command end bit (slots spent in WAIT_RSP count); if more than NCR have already elapsed, SEND SHALL begin on the next istrobe.
REQ-022 SEND SHALL drive 48 bits, one per istrobe, MSB-first: 0, 0, index, arg, CRC7 of the first 40 bits, 1.
REQ-023 ocmd_oe SHALL be 1 from the first SEND slot through the end-bit slot, then 0; the module SHALL then return to IDLE.
REQ-024 When ocmd_oe=0, ocmd SHALL be 1.
REQ-025 icmd SHALL be ignored in WAIT_RSP, GAP and SEND.
REQ-026 istrobe held low SHALL freeze all state, with no timeout.

Reset
REQ-027 While irst=0, the module SHALL be in IDLE with ocmd=1, ocmd_oe=0, ovalid=0, oerr=0, ordy=0, oindex=0, oarg=0, and all counters and the CRC cleared.
REQ-028 Reset asserted mid-RECV or mid-SEND SHALL abort the frame immediately, releasing the line asynchronously.
REQ-029 After reset release, reception SHALL start only on a fresh start bit.

Verification
REQ-030 CMD0 frame 0x400000000095 -> ovalid, oindex=0, oarg=0; irsp_skip -> IDLE, ocmd_oe never asserts.
REQ-031 CMD8 frame 0x48000001AA87, then irsp_valid with index 8, arg 0x1AA -> after NCR=2 slots, line carries 0x08000001AA13, ocmd_oe high for exactly 48 strobes.
REQ-032 CMD17 frame 0x510000000055 with one CRC bit flipped -> oerr pulse, no ovalid, ordy stays 0.
REQ-033 Frame with transmission bit 0 -> oerr on slot 2, IDLE; a following valid CMD0 is accepted.
REQ-034 irsp_valid delayed 10 slots -> SEND starts on the next strobe; irsp_valid pulsed in IDLE -> no response sent.
REQ-035 irst=0 at response bit 20 -> ocmd_oe=0 and ocmd=1 immediately, all outputs at reset values.
